// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : fb_pkg
//  Brief   : Shared constants, state encoding and lane helper for the
//            frame blitter (framebuffer fill + present initiator).
//  Revision: 1.0 - initial release
// ============================================================================
package fb_pkg;

  // Word address of the LED matrix frame-address register.
  localparam logic [31:0] FB_FRAME_REG_ADDR = 32'd0;
  // Bit of the frame register that reads 1 while a new frame is pending.
  localparam int FB_PENDING_BIT = 31;
  // Default framebuffer row stride in 16-bit pixels.
  localparam int FB_STRIDE_HW = 32;

  // RGB565 field positions.
  localparam int FB_R_MSB = 15;
  localparam int FB_R_LSB = 11;
  localparam int FB_G_MSB = 10;
  localparam int FB_G_LSB = 5;
  localparam int FB_B_MSB = 4;
  localparam int FB_B_LSB = 0;

  // One-hot controller states.
  typedef enum logic [6:0] {
    ST_IDLE    = 7'b000_0001,
    ST_SETUP   = 7'b000_0010,
    ST_WRITE   = 7'b000_0100,
    ST_NEXT    = 7'b000_1000,
    ST_PRESENT = 7'b001_0000,
    ST_POLL    = 7'b010_0000,
    ST_DONE    = 7'b100_0000
  } fb_state_t;

  // Place the fill colour on the byte lanes selected for a pixel write.
  function automatic logic [31:0] fb_lane_data(input logic [3:0] sel,
                                               input logic [15:0] color);
    logic [31:0] d;
    case (sel)
      4'b1111: d = {color, color};
      4'b0011: d = {16'h0000, color};
      4'b1100: d = {color, 16'h0000};
      default: d = 32'h0000_0000;
    endcase
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fb_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module  : fb_addr_gen
//  Brief   : Combinational pixel address generator. Maps (base, x, y, xe)
//            to a Wishbone word address, byte selects and the x step.
//  Revision: 1.0 - initial release
// ============================================================================
module fb_addr_gen
  import fb_pkg::*;
#(
  parameter int AW        = 32,
  parameter int STRIDE_HW = FB_STRIDE_HW
) (
  input  logic [14:0]   base,
  input  logic [6:0]    x,
  input  logic [6:0]    y,
  input  logic [6:0]    xe,
  output logic [AW-1:0] adr,
  output logic [3:0]    sel,
  output logic [1:0]    step
);

  logic [14:0] hw;
  logic [6:0]  remaining;

  // Halfword address wraps modulo 2^15; an even address with two pixels
  // left in the row is filled with a full-word write.
  always_comb begin
    hw        = base + (15'(y) * 15'(STRIDE_HW)) + 15'(x);
    adr       = AW'(hw[14:1]);
    remaining = xe - x;
    if (!hw[0] && (remaining >= 7'd2)) begin
      sel  = 4'b1111;
      step = 2'd2;
    end else if (!hw[0]) begin
      sel  = 4'b0011;
      step = 2'd1;
    end else begin
      sel  = 4'b1100;
      step = 2'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/frame_blitter.sv
`default_nettype none
// ============================================================================
//  Module  : frame_blitter
//  Brief   : Wishbone classic-cycle initiator that fills a clipped rectangle
//            of the LED framebuffer with one RGB565 colour and optionally
//            writes the frame-address register of the LED matrix.
//            Build option FRAME_BLITTER_PRESENT_POLL_EN: after presenting,
//            poll the frame register until its pending bit clears.
//  Revision: 1.0 - initial release
// ============================================================================
module frame_blitter
  import fb_pkg::*;
#(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int STRIDE_HW   = FB_STRIDE_HW,
  parameter int MAX_W       = 32,
  parameter int MAX_H       = 16,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic          wb_clk_i,
  input  logic          wb_reset_i,
  input  logic          start,
  input  logic [14:0]   dst_base,
  input  logic [4:0]    x0,
  input  logic [3:0]    y0,
  input  logic [5:0]    w,
  input  logic [4:0]    h,
  input  logic [15:0]   color,
  input  logic          present,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] wb_adr_o,
  output logic [DW-1:0] wb_dat_o,
  input  logic [DW-1:0] wb_dat_i,
  output logic          wb_we_o,
  output logic [3:0]    wb_sel_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  input  logic          wb_ack_i
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  fb_state_t        state;
  logic [14:0]      base_r;
  logic [4:0]       x0_r;
  logic [3:0]       y0_r;
  logic [5:0]       w_r;
  logic [4:0]       h_r;
  logic [15:0]      color_r;
  logic             present_r;
  logic [6:0]       x;
  logic [6:0]       y;
  logic [CNT_W-1:0] ack_cnt;
`ifdef FRAME_BLITTER_PRESENT_POLL_EN
  logic [1:0]       gap_cnt;
`endif

  logic [6:0]    x_sum, y_sum, xe, ye, y_inc;
  logic          clip_empty;
  logic [AW-1:0] gen_adr;
  logic [3:0]    gen_sel;
  logic [1:0]    gen_step;
  logic          unused_dat;

  // Only the pending bit of read data matters; fold the rest away.
  assign unused_dat = ^wb_dat_i;

  // Clip the rectangle against the visible area in 7-bit arithmetic.
  always_comb begin
    x_sum      = 7'(x0_r) + 7'(w_r);
    y_sum      = 7'(y0_r) + 7'(h_r);
    xe         = (x_sum > 7'(MAX_W)) ? 7'(MAX_W) : x_sum;
    ye         = (y_sum > 7'(MAX_H)) ? 7'(MAX_H) : y_sum;
    clip_empty = (7'(x0_r) >= xe) || (7'(y0_r) >= ye);
    y_inc      = y + 7'd1;
  end

  fb_addr_gen #(
    .AW        (AW),
    .STRIDE_HW (STRIDE_HW)
  ) u_addr_gen (
    .base (base_r),
    .x    (x),
    .y    (y),
    .xe   (xe),
    .adr  (gen_adr),
    .sel  (gen_sel),
    .step (gen_step)
  );

  // Controller: sequences fill writes, present write, optional poll reads,
  // and guards every outstanding transfer with the ack timeout.
  always_ff @(posedge wb_clk_i) begin
    if (wb_reset_i) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      wb_adr_o  <= '0;
      wb_dat_o  <= '0;
      wb_we_o   <= 1'b0;
      wb_sel_o  <= 4'b0000;
      wb_cyc_o  <= 1'b0;
      wb_stb_o  <= 1'b0;
      base_r    <= '0;
      x0_r      <= '0;
      y0_r      <= '0;
      w_r       <= '0;
      h_r       <= '0;
      color_r   <= '0;
      present_r <= 1'b0;
      x         <= '0;
      y         <= '0;
      ack_cnt   <= '0;
`ifdef FRAME_BLITTER_PRESENT_POLL_EN
      gap_cnt   <= '0;
`endif
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (wb_cyc_o && !wb_ack_i) begin
        // Waiting on the slave: abort once the budget is used up.
        if (ack_cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
          wb_cyc_o <= 1'b0;
          wb_stb_o <= 1'b0;
          wb_we_o  <= 1'b0;
          busy     <= 1'b0;
          err      <= 1'b1;
          state    <= ST_IDLE;
        end else begin
          ack_cnt <= ack_cnt + 1'b1;
        end
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              if (dst_base < 15'd2) begin
                // Base below 2 would let pixels land on the frame register.
                err <= 1'b1;
              end else begin
                base_r    <= dst_base;
                x0_r      <= x0;
                y0_r      <= y0;
                w_r       <= w;
                h_r       <= h;
                color_r   <= color;
                present_r <= present;
                busy      <= 1'b1;
                state     <= ST_SETUP;
              end
            end
          end

          ST_SETUP: begin
            x <= 7'(x0_r);
            y <= 7'(y0_r);
            if (!clip_empty) begin
              state <= ST_WRITE;
            end else if (present_r) begin
              state <= ST_PRESENT;
            end else begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= ST_DONE;
            end
          end

          ST_WRITE: begin
            if (!wb_cyc_o) begin
              wb_adr_o <= gen_adr;
              wb_sel_o <= gen_sel;
              wb_dat_o <= DW'(fb_lane_data(gen_sel, color_r));
              wb_we_o  <= 1'b1;
              wb_cyc_o <= 1'b1;
              wb_stb_o <= 1'b1;
              ack_cnt  <= '0;
            end else begin
              wb_cyc_o <= 1'b0;
              wb_stb_o <= 1'b0;
              wb_we_o  <= 1'b0;
              x        <= x + 7'(gen_step);
              state    <= ST_NEXT;
            end
          end

          ST_NEXT: begin
            if (x >= xe) begin
              x <= 7'(x0_r);
              y <= y_inc;
              if (y_inc < ye) begin
                state <= ST_WRITE;
              end else if (present_r) begin
                state <= ST_PRESENT;
              end else begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= ST_DONE;
              end
            end else begin
              state <= ST_WRITE;
            end
          end

          ST_PRESENT: begin
            if (!wb_cyc_o) begin
              wb_adr_o <= AW'(FB_FRAME_REG_ADDR);
              wb_sel_o <= 4'b1111;
              wb_dat_o <= DW'({16'h0000, base_r, 1'b0});
              wb_we_o  <= 1'b1;
              wb_cyc_o <= 1'b1;
              wb_stb_o <= 1'b1;
              ack_cnt  <= '0;
            end else begin
              wb_cyc_o <= 1'b0;
              wb_stb_o <= 1'b0;
              wb_we_o  <= 1'b0;
`ifdef FRAME_BLITTER_PRESENT_POLL_EN
              gap_cnt  <= '0;
              state    <= ST_POLL;
`else
              done     <= 1'b1;
              busy     <= 1'b0;
              state    <= ST_DONE;
`endif
            end
          end

          ST_POLL: begin
`ifdef FRAME_BLITTER_PRESENT_POLL_EN
            if (!wb_cyc_o) begin
              if (gap_cnt != 2'd0) begin
                gap_cnt <= gap_cnt - 2'd1;
              end else begin
                wb_adr_o <= AW'(FB_FRAME_REG_ADDR);
                wb_sel_o <= 4'b1111;
                wb_we_o  <= 1'b0;
                wb_cyc_o <= 1'b1;
                wb_stb_o <= 1'b1;
                ack_cnt  <= '0;
              end
            end else begin
              wb_cyc_o <= 1'b0;
              wb_stb_o <= 1'b0;
              if (!wb_dat_i[FB_PENDING_BIT]) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= ST_DONE;
              end else begin
                // Four idle cycles before the next read of the register.
                gap_cnt <= 2'd3;
              end
            end
`else
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_DONE;
`endif
          end

          ST_DONE: begin
            state <= ST_IDLE;
          end

          default: begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire
